// File: rtl/udp_encoder.sv
// udp_encoder
//   Builds one UDP datagram as a stream of 32-bit words. The host starts a
//   datagram with the header fields, then writes ceil(len_data/4) payload
//   words. The payload is buffered while a one's-complement checksum is
//   accumulated over the IPv4 pseudo-header, the UDP header and the payload.
//   The block then emits {src_port,dest_port}, {len_udp,checksum} and the
//   buffered payload words back to back, followed by a one-cycle fin pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      begin a datagram (sampled only while idle)
//   dest_ip    destination IPv4 address (pseudo-header only)
//   src_ip     source IPv4 address (pseudo-header only)
//   src_port   UDP source port
//   dest_port  UDP destination port
//   len_data   payload length in bytes (at most 4*MAX_WORDS)
//   data_in    payload word, first byte in [31:24]
//   wr_en      data_in valid (accepted only while loading)
//   data_out   datagram word
//   valid      data_out valid
//   len_udp    len_data+8 of the last accepted datagram
//   busy       high whenever a datagram is in progress
//   fin        one-cycle pulse after the last word
//   error      one-cycle pulse when a start is rejected (payload too long)
module udp_encoder #(
    parameter int MAX_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dest_ip,
    input  logic [31:0] src_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dest_port,
    input  logic [15:0] len_data,
    input  logic [31:0] data_in,
    input  logic        wr_en,
    output logic [31:0] data_out,
    output logic        valid,
    output logic [15:0] len_udp,
    output logic        busy,
    output logic        fin,
    output logic        error
);

    localparam int          AW        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int          CW        = $clog2(MAX_WORDS + 1);
    localparam logic [15:0] MAX_BYTES = 16'(4 * MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SUM  = 3'd2,
        S_HDR1 = 3'd3,
        S_HDR2 = 3'd4,
        S_DATA = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  n_q, n_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [31:0]    acc_q, acc_d;
    logic [15:0]    csum_q, csum_d;
    logic [15:0]    len_udp_q, len_udp_d;
    logic [15:0]    src_port_q, src_port_d;
    logic [15:0]    dest_port_q, dest_port_d;
    logic [1:0]     len_rem_q, len_rem_d;
    logic [31:0]    data_out_q, data_out_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           fin_q, fin_d;
    logic           error_q, error_d;

    logic [31:0]    buf_q [MAX_WORDS];
    logic           wr_s;
    logic [AW-1:0]  wr_addr_s;
    logic [31:0]    wr_word_s;
    logic [CW-1:0]  n_s;

    // Pseudo-header plus UDP header contribution; at most nine 16-bit terms, so no carry out.
    function automatic logic [31:0] seed_sum(input logic [31:0] sip, input logic [31:0] dip,
                                             input logic [15:0] lu, input logic [15:0] sp,
                                             input logic [15:0] dp);
        return {16'd0, sip[31:16]} + {16'd0, sip[15:0]} +
               {16'd0, dip[31:16]} + {16'd0, dip[15:0]} +
               32'h0000_0011 + {16'd0, lu} + {16'd0, sp} + {16'd0, dp} + {16'd0, lu};
    endfunction

    // Add both halves of a word with end-around carry; 2^32-1 is a multiple of 2^16-1,
    // so folding at 32 bits preserves the 16-bit one's-complement sum.
    function automatic logic [31:0] acc_add(input logic [31:0] acc, input logic [31:0] word);
        logic [32:0] sum;
        sum = {1'b0, acc} + {17'd0, word[31:16]} + {17'd0, word[15:0]};
        return sum[31:0] + {31'd0, sum[32]};
    endfunction

    // Fold to 16 bits, complement, and send an all-zero result as 0xFFFF.
    function automatic logic [15:0] csum_fold(input logic [31:0] acc);
        logic [16:0] s1;
        logic [15:0] s2;
        logic [15:0] cs;
        s1 = {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
        s2 = s1[15:0] + {15'd0, s1[16]};
        cs = ~s2;
        if (cs == 16'h0000) begin
            return 16'hFFFF;
        end else begin
            return cs;
        end
    endfunction

    // Zero the bytes of the final word that lie beyond len_data.
    function automatic logic [31:0] mask_tail(input logic [31:0] word, input logic [1:0] rem);
        case (rem)
            2'd1:    return {word[31:24], 24'd0};
            2'd2:    return {word[31:16], 16'd0};
            2'd3:    return {word[31:8], 8'd0};
            default: return word;
        endcase
    endfunction

    assign n_s = CW'((len_data + 16'd3) >> 2);

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        csum_d      = csum_q;
        len_udp_d   = len_udp_q;
        src_port_d  = src_port_q;
        dest_port_d = dest_port_q;
        len_rem_d   = len_rem_q;
        data_out_d  = 32'd0;
        valid_d     = 1'b0;
        fin_d       = 1'b0;
        error_d     = 1'b0;
        wr_s        = 1'b0;
        wr_addr_s   = idx_q[AW-1:0];
        wr_word_s   = data_in;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_data > MAX_BYTES) begin
                        error_d = 1'b1;
                    end else begin
                        len_udp_d   = len_data + 16'd8;
                        src_port_d  = src_port;
                        dest_port_d = dest_port;
                        len_rem_d   = len_data[1:0];
                        n_d         = n_s;
                        idx_d       = '0;
                        acc_d       = seed_sum(src_ip, dest_ip, len_data + 16'd8,
                                               src_port, dest_port);
                        if (n_s == '0) begin
                            state_d = S_SUM;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (wr_en) begin
                    wr_s = 1'b1;
                    if (idx_q == n_q - CW'(1)) begin
                        wr_word_s = mask_tail(data_in, len_rem_q);
                        state_d   = S_SUM;
                    end else begin
                        wr_word_s = data_in;
                        state_d   = S_LOAD;
                    end
                    acc_d = acc_add(acc_q, wr_word_s);
                    idx_d = idx_q + CW'(1);
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_SUM: begin
                csum_d     = csum_fold(acc_q);
                state_d    = S_HDR1;
                valid_d    = 1'b1;
                data_out_d = {src_port_q, dest_port_q};
            end
            S_HDR1: begin
                state_d    = S_HDR2;
                valid_d    = 1'b1;
                data_out_d = {len_udp_q, csum_q};
            end
            S_HDR2: begin
                if (n_q == '0) begin
                    state_d = S_FIN;
                    fin_d   = 1'b1;
                end else begin
                    state_d    = S_DATA;
                    valid_d    = 1'b1;
                    data_out_d = buf_q[0];
                    idx_d      = CW'(1);
                end
            end
            S_DATA: begin
                // idx_q is the index of the next word to present.
                if (idx_q == n_q) begin
                    state_d = S_FIN;
                    fin_d   = 1'b1;
                end else begin
                    state_d    = S_DATA;
                    valid_d    = 1'b1;
                    data_out_d = buf_q[idx_q[AW-1:0]];
                    idx_d      = idx_q + CW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            acc_q       <= 32'd0;
            csum_q      <= 16'd0;
            len_udp_q   <= 16'd0;
            src_port_q  <= 16'd0;
            dest_port_q <= 16'd0;
            len_rem_q   <= 2'd0;
            data_out_q  <= 32'd0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            csum_q      <= csum_d;
            len_udp_q   <= len_udp_d;
            src_port_q  <= src_port_d;
            dest_port_q <= dest_port_d;
            len_rem_q   <= len_rem_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            fin_q       <= fin_d;
            error_q     <= error_d;
        end
    end

    // Payload buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            buf_q[wr_addr_s] <= wr_word_s;
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign len_udp  = len_udp_q;
    assign busy     = busy_q;
    assign fin      = fin_q;
    assign error    = error_q;

endmodule

// File: tb/tb_udp_encoder.sv
// tb_udp_encoder
//   Randomised bench for udp_encoder. Each issued datagram pushes its expected
//   words (from a byte-level one's-complement model) into a queue; a monitor
//   pops and compares on every valid cycle.
module tb_udp_encoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dest_ip;
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic [15:0] dest_port;
    logic [15:0] len_data;
    logic [31:0] data_in;
    logic        wr_en;
    logic [31:0] data_out;
    logic        valid;
    logic [15:0] len_udp;
    logic        busy;
    logic        fin;
    logic        error;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          run    = 0;
    int          last_run = 0;
    logic [31:0] exp_q [$];
    logic [31:0] pay_w [$];
    logic [7:0]  pay_b [$];
    logic [31:0] mon_e;
    logic [15:0] last_len_udp;

    udp_encoder #(.MAX_WORDS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dest_ip   (dest_ip),
        .src_ip    (src_ip),
        .src_port  (src_port),
        .dest_port (dest_port),
        .len_data  (len_data),
        .data_in   (data_in),
        .wr_en     (wr_en),
        .data_out  (data_out),
        .valid     (valid),
        .len_udp   (len_udp),
        .busy      (busy),
        .fin       (fin),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference checksum over the pseudo-header, UDP header and the bytes in pay_b.
    function automatic logic [15:0] ref_csum(input logic [31:0] sip, input logic [31:0] dip,
                                             input logic [15:0] sp, input logic [15:0] dp,
                                             input logic [15:0] len);
        longint unsigned s;
        logic [15:0]     r;
        logic [15:0]     pair;
        s = 64'(sip[31:16]) + 64'(sip[15:0]) + 64'(dip[31:16]) + 64'(dip[15:0]) +
            64'd17 + 64'd2 * (64'(len) + 64'd8) + 64'(sp) + 64'(dp);
        for (int k = 0; k < pay_b.size(); k += 2) begin
            pair = {pay_b[k], (k + 1 < pay_b.size()) ? pay_b[k + 1] : 8'h00};
            s += 64'(pair);
        end
        while ((s >> 16) != 64'd0) s = (s & 64'hFFFF) + (s >> 16);
        r = ~s[15:0];
        if (r == 16'h0000) r = 16'hFFFF;
        return r;
    endfunction

    // Monitor: every valid cycle must match the head of the expectation queue.
    always @(negedge clk) begin
        if (valid) begin
            run = run + 1;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_word: got %h expected none", data_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("data_word", data_out, mon_e);
            end
        end else if (run != 0) begin
            last_run = run;
            run = 0;
        end
    end

    // Issue one datagram using the words in pay_w; start is driven immediately.
    task automatic issue(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                         input logic [15:0] dp, input logic [15:0] len, input int gap,
                         input bit spur);
        int          n;
        logic [31:0] w;
        logic [15:0] cs;
        n = (int'(len) + 3) / 4;
        pay_b.delete();
        for (int i = 0; i < int'(len); i++) begin
            w = pay_w[i / 4];
            pay_b.push_back(8'(w >> (24 - 8 * (i % 4))));
        end
        cs = ref_csum(sip, dip, sp, dp, len);
        exp_q.push_back({sp, dp});
        exp_q.push_back({len + 16'd8, cs});
        for (int wi = 0; wi < n; wi++) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++) begin
                if (4 * wi + j < int'(len)) w = w | (32'(pay_b[4 * wi + j]) << (24 - 8 * j));
            end
            exp_q.push_back(w);
        end
        last_len_udp = len + 16'd8;
        src_ip = sip; dest_ip = dip; src_port = sp; dest_port = dp; len_data = len;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        src_ip = $urandom; dest_ip = $urandom; src_port = 16'($urandom);
        dest_port = 16'($urandom); len_data = 16'($urandom);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1; data_in = pay_w[i];
            @(posedge clk); #1;
            wr_en = 1'b0; data_in = $urandom;
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    start = spur;
                    len_data = 16'($urandom_range(0, 64));
                    @(posedge clk); #1;
                    start = 1'b0;
                end
            end
        end
    endtask

    // Wait (bounded) for fin, optionally hammering start/wr_en meanwhile, then check the tail.
    task automatic wait_fin(input int exp_run, input bit spur);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (fin) begin
                seen = 1'b1;
                break;
            end
            if (spur) begin
                start = 1'b1; wr_en = 1'b1; data_in = $urandom;
                len_data = 16'($urandom_range(0, 64));
            end
        end
        start = 1'b0; wr_en = 1'b0;
        chk("fin_seen", 32'(seen), 32'd1);
        chk("fin_valid_low", 32'(valid), 32'd0);
        chk("fin_data_zero", data_out, 32'd0);
        chk("fin_busy", 32'(busy), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("valid_run", 32'(last_run), 32'(exp_run));
        chk("fin_one_cycle", 32'(fin), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("len_udp_held", 32'(len_udp), 32'(last_len_udp));
        exp_q.delete();
    endtask

    task automatic rand_payload(input int n);
        pay_w.delete();
        for (int i = 0; i < n; i++) pay_w.push_back($urandom);
    endtask

    initial begin
        logic [15:0] hs;
        logic [15:0] len;
        bit          seen;
        int          cnt;
        reset = 1'b0; start = 1'b0; wr_en = 1'b0; data_in = 32'd0;
        src_ip = 32'd0; dest_ip = 32'd0; src_port = 16'd0; dest_port = 16'd0; len_data = 16'd0;
        last_len_udp = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_len_udp", 32'(len_udp), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fin", 32'(fin), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Empty payload with the reference fields.
        pay_w.delete();
        issue(32'hC0A80001, 32'hC0A80002, 16'h1234, 16'h5678, 16'd0, 0, 1'b0);
        wait_fin(2, 1'b0);

        // Five bytes: tail of the second word must be masked.
        pay_w.delete(); pay_w.push_back(32'hDEADBEEF); pay_w.push_back(32'hABCDEF01);
        issue(32'hC0A80001, 32'hC0A80002, 16'h1234, 16'h5678, 16'd5, 0, 1'b0);
        wait_fin(4, 1'b0);

        // Largest accepted payload.
        rand_payload(16);
        issue($urandom, $urandom, 16'($urandom), 16'($urandom), 16'd64, 0, 1'b0);
        wait_fin(18, 1'b0);

        // Oversized payload is rejected.
        len_data = 16'd65; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", 32'(error), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_valid", 32'(valid), 32'd0);
        @(posedge clk); #1;
        chk("err_one_cycle", 32'(error), 32'd0);
        chk("err_busy_after", 32'(busy), 32'd0);
        chk("err_len_udp_held", 32'(len_udp), 32'(last_len_udp));

        // Payload chosen so the complemented sum is zero; 0xFFFF must be sent.
        src_ip = $urandom; dest_ip = $urandom; src_port = 16'($urandom); dest_port = 16'($urandom);
        pay_b.delete();
        hs = ~ref_csum(src_ip, dest_ip, src_port, dest_port, 16'd4);
        pay_w.delete(); pay_w.push_back({16'hFFFF - hs, 16'h0000});
        issue(src_ip, dest_ip, src_port, dest_port, 16'd4, 0, 1'b0);
        wait_fin(3, 1'b0);

        // Same datagram gap-free, then with wr_en gaps and spurious starts/writes.
        rand_payload(3);
        issue(32'h0A000001, 32'h0A000002, 16'h0400, 16'h0035, 16'd11, 0, 1'b0);
        wait_fin(5, 1'b0);
        issue(32'h0A000001, 32'h0A000002, 16'h0400, 16'h0035, 16'd11, 3, 1'b1);
        wait_fin(5, 1'b1);

        // Random datagrams, back to back.
        for (int r = 0; r < 8; r++) begin
            len = 16'($urandom_range(0, 64));
            rand_payload(16);
            issue($urandom, $urandom, 16'($urandom), 16'($urandom), len,
                  int'($urandom_range(0, 2)), 1'($urandom));
            wait_fin((int'(len) + 3) / 4 + 2, 1'b0);
        end

        // Asynchronous reset in the middle of the data phase.
        rand_payload(10);
        issue($urandom, $urandom, 16'($urandom), 16'($urandom), 16'd40, 0, 1'b0);
        seen = 1'b0; cnt = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (valid) cnt++;
            if (cnt == 4) begin
                seen = 1'b1;
                break;
            end
        end
        chk("reached_data", 32'(seen), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_data_out", data_out, 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_len_udp", 32'(len_udp), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_fin", 32'(fin), 32'd0);
        chk("arst_error", 32'(error), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rand_payload(4);
        issue($urandom, $urandom, 16'($urandom), 16'($urandom), 16'd14, 1, 1'b0);
        wait_fin(6, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/udp_encoder.md
Name: udp_encoder

Overview:
Builds one UDP datagram as a stream of 32-bit words from header fields and a payload written in by the host. Payload words are buffered while the one's-complement checksum is accumulated over the pseudo-header, UDP header and payload. The block then emits the header (ports, length, checksum) followed by the buffered payload. It sits between the application-side payload source and the IP transmit path; it is the transmit counterpart of the UDP receive decoder.

Parameters:
MAX_WORDS, 16, payload buffer depth in 32-bit words; maximum payload is 4*MAX_WORDS bytes.

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin datagram; sampled only in IDLE
dest_ip  in  32  destination IPv4 address (pseudo-header only)
src_ip  in  32  source IPv4 address (pseudo-header only)
src_port  in  16  UDP source port
dest_port  in  16  UDP destination port
len_data  in  16  payload length in bytes
data_in  in  32  payload word, first byte in [31:24]
wr_en  in  1  data_in valid; accepted only in LOAD
data_out  out  32  datagram word
valid  out  1  data_out valid
len_udp  out  16  len_data+8, held from start until next start
busy  out  1  high in every state except IDLE
fin  out  1  one-cycle pulse after the last word is sent
error  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; data_out=0, valid=0, len_udp=0, busy=0, fin=0, error=0; word counters and checksum accumulator cleared. Buffer contents are don't-care. Reset mid-datagram aborts with no further output.
- States: IDLE, LOAD, SUM, HDR1, HDR2, DATA, FIN.
- IDLE: on start=1:
  - If len_data > 4*MAX_WORDS: error=1 for one cycle, stay in IDLE.
  - Otherwise latch all fields, set len_udp=len_data+8, and compute n=ceil(len_data/4). Go to LOAD, or to SUM if n=0.
  - The accumulator is seeded with src_ip[31:16], src_ip[15:0], dest_ip[31:16], dest_ip[15:0], 0x0011, len_udp, src_port, dest_port, len_udp.
- LOAD: each cycle with wr_en=1, store data_in at the write index and add both halves to the accumulator.
  - The final word (index n-1) is masked before storing and summing: bytes beyond len_data are zeroed (len mod 4 = 1 keeps [31:24], 2 keeps [31:16], 3 keeps [31:8]).
  - After the n-th accepted word, go to SUM. wr_en=0 stalls indefinitely.
- SUM: one cycle. Fold the carries into 16 bits and complement. A result of 0x0000 is replaced by 0xFFFF. Go to HDR1.
- HDR1: valid=1, data_out={src_port,dest_port}.
- HDR2: valid=1, data_out={len_udp,checksum}.
- DATA: valid=1, data_out=buffer[i] for i=0..n-1, one word per cycle with no gaps; then FIN. If n=0, go HDR2→FIN.
- FIN: fin=1, valid=0, data_out=0 for one cycle; then IDLE.
- Outputs are registered. valid is high for exactly n+2 consecutive cycles per datagram.
- Ignored inputs:
  - start outside IDLE.
  - wr_en outside LOAD; extra wr_en after the n-th word is dropped.
  - Field inputs after the start cycle.
- Latency: minimum start-to-first-valid is n+2 cycles (LOAD n, SUM 1); 2 cycles if n=0.
- Accumulator: 32-bit with end-around carry folding so no overflow is lost; upper-half carries are folded in SUM.
- Back-to-back operation: start may be asserted in the IDLE cycle immediately after FIN.

Test Plan:
- len_data=0, src_ip=0xC0A80001, dest_ip=0xC0A80002, src_port=0x1234, dest_port=0x5678 → valid for 2 cycles: 0x12345678, then 0x000815DE; then fin pulse.
- Same fields, len_data=5, words 0xDEADBEEF, 0xABCDEF01 → output 0x12345678, {0x000D,cs}, 0xDEADBEEF, 0xAB000000, where cs matches an independent one's-complement model.
- len_data=64 with MAX_WORDS=16 is accepted (16 data words, valid 18 cycles); len_data=65 → error pulse, busy stays 0, no valid.
- Payload arranged so the complemented sum is 0x0000 → transmitted checksum is 0xFFFF.
- wr_en gaps of 3 cycles between words, plus start pulses during LOAD/DATA → output identical to the gap-free case; the spurious starts are ignored.
- reset driven low during DATA → all outputs 0 immediately (asynchronous); after release, a new start produces a correct datagram.
